// File: rtl/dm9000a_reg_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : dm9000a_reg_reader_pkg                                           |
// | Shared FSM state type, DM9000A register indices and the phase timer width  |
// | used by the DM9000A host-side read engine.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dm9000a_reg_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_I_SETUP = 3'd1,
        ST_I_STB   = 3'd2,
        ST_I_HOLD  = 3'd3,
        ST_GAP     = 3'd4,
        ST_R_SETUP = 3'd5,
        ST_R_STB   = 3'd6,
        ST_R_HOLD  = 3'd7
    } rd_state_t;

    // DM9000A register indices
    localparam logic [7:0] IDX_NCR    = 8'h00;
    localparam logic [7:0] IDX_NSR    = 8'h01;
    localparam logic [7:0] IDX_MRCMDX = 8'hF0;
    localparam logic [7:0] IDX_MRCMD  = 8'hF2;
    localparam logic [7:0] IDX_ISR    = 8'hFE;

    // Width of the phase timer load value; phases up to 255 cycles
    localparam int TMR_W = 8;

endpackage
`default_nettype wire

// File: rtl/dm9000a_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dm9000a_phase_timer                                              |
// | Loadable down-counter. After a load of N (N>=1) the done output pulses     |
// | high during the N-th cycle, i.e. the last cycle of the phase. A new load   |
// | in that same cycle starts the next phase without a bubble.                 |
// | Ports   : clk100, rst (sync, active-high), load, load_val, done            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dm9000a_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk100,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         run_q, run_d;

    assign done = run_q && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load) begin
            // A zero load is treated as a one-cycle phase
            cnt_d = (load_val == '0) ? '0 : load_val - 1'b1;
            run_d = 1'b1;
        end else if (done) begin
            run_d = 1'b0;
        end else if (run_q) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dm9000a_reg_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dm9000a_reg_reader                                               |
// | Host-side read engine for the DM9000A 16-bit bus. Each request performs    |
// | one INDEX write cycle followed by N DATA read cycles; every sampled word   |
// | is presented on a single-register valid/ready stream.                      |
// | Ports   : clk100, rst                  clock / sync active-high reset      |
// |           req_valid/ready/index/count  request handshake                   |
// |           rd_data/valid/ready/last     word stream                         |
// |           busy                         request in progress                 |
// |           enet_*                       DM9000A bus pins (tristate at top)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dm9000a_reg_reader
    import dm9000a_reg_reader_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int WSTB_CYC  = 2,
    parameter int RSTB_CYC  = 4,
    parameter int HOLD_CYC  = 1,
    parameter int GAP_CYC   = 2,
    parameter int CNT_W     = 12
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_index,
    input  logic [CNT_W-1:0] req_count,
    output logic [15:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             rd_last,
    output logic             busy,
    input  logic [15:0]      enet_data_i,
    output logic [15:0]      enet_data_o,
    output logic             enet_data_oe,
    output logic             enet_cmd,
    output logic             enet_cs_n,
    output logic             enet_rd_n,
    output logic             enet_wr_n
);

    localparam logic [TMR_W-1:0] C_SETUP = TMR_W'(SETUP_CYC);
    localparam logic [TMR_W-1:0] C_WSTB  = TMR_W'(WSTB_CYC);
    localparam logic [TMR_W-1:0] C_RSTB  = TMR_W'(RSTB_CYC);
    localparam logic [TMR_W-1:0] C_HOLD  = TMR_W'(HOLD_CYC);
    localparam logic [TMR_W-1:0] C_GAP   = TMR_W'(GAP_CYC);

    rd_state_t        state_q, state_d;
    logic [7:0]       index_q, index_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_last_q, rd_last_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic [15:0]      data_o_q, data_o_d;
    logic             oe_q, oe_d;
    logic             cmd_q, cmd_d;
    logic             cs_n_q, cs_n_d;
    logic             rd_n_q, rd_n_d;
    logic             wr_n_q, wr_n_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    logic             accept;
    logic             stall;
    logic             capture;

    dm9000a_phase_timer #(.W(TMR_W)) u_timer (
        .clk100   (clk100),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign accept  = req_valid && req_ready_q;
    // Output register still occupied at the coming edge
    assign stall   = rd_valid_q && !rd_ready;
    assign capture = (state_q == ST_R_STB) && tmr_done;

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        remain_d   = remain_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;

        case (state_q)
            ST_IDLE: if (accept) begin
                state_d  = ST_I_SETUP;
                tmr_load = 1'b1;
                tmr_val  = C_SETUP;
                index_d  = req_index;
                remain_d = (req_count == '0) ? CNT_W'(1) : req_count;
            end
            ST_I_SETUP: if (tmr_done) begin
                state_d  = ST_I_STB;
                tmr_load = 1'b1;
                tmr_val  = C_WSTB;
            end
            ST_I_STB: if (tmr_done) begin
                state_d  = ST_I_HOLD;
                tmr_load = 1'b1;
                tmr_val  = C_HOLD;
            end
            ST_I_HOLD: if (tmr_done) begin
                state_d  = ST_GAP;
                tmr_load = 1'b1;
                tmr_val  = C_GAP;
            end
            ST_GAP: if (tmr_done) begin
                tmr_load = 1'b1;
                if (stall) begin
                    // Stretch the gap one cycle at a time until the word drains
                    tmr_val = TMR_W'(1);
                end else begin
                    state_d = ST_R_SETUP;
                    tmr_val = C_SETUP;
                end
            end
            ST_R_SETUP: if (tmr_done) begin
                state_d  = ST_R_STB;
                tmr_load = 1'b1;
                tmr_val  = C_RSTB;
            end
            ST_R_STB: if (tmr_done) begin
                state_d  = ST_R_HOLD;
                tmr_load = 1'b1;
                tmr_val  = C_HOLD;
                remain_d = remain_q - 1'b1;
            end
            ST_R_HOLD: if (tmr_done) begin
                if (remain_q != '0) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = C_GAP;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Consume first so a same-edge capture overrides it
        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end
        if (capture) begin
            rd_data_d  = enet_data_i;
            rd_valid_d = 1'b1;
            rd_last_d  = (remain_q == CNT_W'(1));
        end

        // Bus pins are registered from the next state so they align with it
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        cs_n_d      = (state_d == ST_IDLE);
        oe_d        = (state_d == ST_I_SETUP) || (state_d == ST_I_STB) ||
                      (state_d == ST_I_HOLD);
        cmd_d       = (state_d == ST_GAP) || (state_d == ST_R_SETUP) ||
                      (state_d == ST_R_STB) || (state_d == ST_R_HOLD);
        wr_n_d      = (state_d != ST_I_STB);
        rd_n_d      = (state_d != ST_R_STB);
        data_o_d    = oe_d ? {8'h00, index_d} : 16'h0000;
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            remain_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            data_o_q    <= '0;
            oe_q        <= 1'b0;
            cmd_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            remain_q    <= remain_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            data_o_q    <= data_o_d;
            oe_q        <= oe_d;
            cmd_q       <= cmd_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign rd_last      = rd_last_q;
    assign busy         = busy_q;
    assign enet_data_o  = data_o_q;
    assign enet_data_oe = oe_q;
    assign enet_cmd     = cmd_q;
    assign enet_cs_n    = cs_n_q;
    assign enet_rd_n    = rd_n_q;
    assign enet_wr_n    = wr_n_q;

endmodule
`default_nettype wire

// File: tb/tb_dm9000a_reg_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dm9000a_reg_reader                                            |
// | Bench for dm9000a_reg_reader: a bus model returns base+k for the k-th read |
// | strobe of a request; a queue of expected words is checked on every        |
// | handshake, plus bus-protocol invariants and literal timing/data checks.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dm9000a_reg_reader;

    logic        clk100 = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_index = 8'h00;
    logic [11:0] req_count = 12'd0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic        rd_last;
    logic        busy;
    logic [15:0] enet_data_i = 16'h0000;
    logic [15:0] enet_data_o;
    logic        enet_data_oe;
    logic        enet_cmd;
    logic        enet_cs_n;
    logic        enet_rd_n;
    logic        enet_wr_n;

    dm9000a_reg_reader dut (
        .clk100       (clk100),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_index    (req_index),
        .req_count    (req_count),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_last      (rd_last),
        .busy         (busy),
        .enet_data_i  (enet_data_i),
        .enet_data_o  (enet_data_o),
        .enet_data_oe (enet_data_oe),
        .enet_cmd     (enet_cmd),
        .enet_cs_n    (enet_cs_n),
        .enet_rd_n    (enet_rd_n),
        .enet_wr_n    (enet_wr_n)
    );

    always #5 clk100 = ~clk100;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always @(posedge clk100) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Model state
    logic [16:0] exp_q[$];      // {last, data}
    int          appear_q[$];   // cycle each new word became visible
    logic [15:0] bus_base = 16'h0000;
    int          bus_k = 0;
    logic [7:0]  cur_idx = 8'h00;
    int          wr_low = 0;
    int          rd_low = 0;
    int          n_consumed = 0;
    logic [15:0] last_data = 16'h0000;
    logic        last_flag = 1'b0;
    int          acc = 0;

    logic prev_valid = 1'b0, prev_hs = 1'b0, prev_rd_n = 1'b1;
    logic prev_strb = 1'b0, prev_cmd = 1'b0;

    // Bus model and compare process
    always @(negedge clk100) begin
        logic [16:0] e;
        if (prev_rd_n == 1'b0 && enet_rd_n == 1'b1) bus_k++;
        enet_data_i = bus_base + 16'(bus_k);
        if (!rst) begin
            if (!enet_wr_n || !enet_rd_n)
                chk(enet_wr_n || enet_rd_n, "strobe_overlap", 0, 1);
            if (!enet_wr_n) begin
                wr_low++;
                chk(enet_data_o == {8'h00, cur_idx} && enet_data_oe && !enet_cmd,
                    "index_cycle_bus", {15'd0, enet_cmd, enet_data_o}, {16'd0, 8'h00, cur_idx});
            end
            if (!enet_rd_n) begin
                rd_low++;
                chk(enet_cmd && !enet_data_oe, "read_cycle_cmd_oe",
                    {enet_data_oe, enet_cmd}, 2'b01);
                chk(!rd_valid, "read_while_word_pending", rd_valid, 0);
            end
            if (prev_strb && (!enet_wr_n || !enet_rd_n))
                chk(enet_cmd == prev_cmd, "cmd_stable_in_strobe", enet_cmd, prev_cmd);
            if (rd_valid && (!prev_valid || prev_hs)) appear_q.push_back(cyc);
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_word", {15'd0, rd_last, rd_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({rd_last, rd_data} == e, "word", {15'd0, rd_last, rd_data}, {15'd0, e});
                end
                n_consumed++;
                last_data = rd_data;
                last_flag = rd_last;
            end
        end
        prev_valid = rd_valid;
        prev_hs    = rd_valid && rd_ready;
        prev_rd_n  = enet_rd_n;
        prev_strb  = !enet_wr_n || !enet_rd_n;
        prev_cmd   = enet_cmd;
    end

    task automatic do_req(input logic [7:0] idx, input logic [11:0] cnt,
                          input logic [15:0] base);
        int n;
        n = (cnt == 0) ? 1 : int'(cnt);
        @(posedge clk100); #1;
        req_index = idx; req_count = cnt; req_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk100);
            if (req_ready) break;
        end
        if (!req_ready) chk(0, "req_ready_timeout", 0, 1);
        @(posedge clk100); #1;
        req_valid = 1'b0;
        acc = cyc;
        cur_idx = idx; bus_base = base; bus_k = 0;
        wr_low = 0; rd_low = 0; n_consumed = 0;
        appear_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), base + 16'(k)});
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk100);
            if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
        end
        chk(ok, "request_completion", ok, 1);
    endtask

    initial begin
        int strb;
        bit ok;
        // Reset state
        repeat (2) @(posedge clk100);
        @(negedge clk100);
        chk(req_ready == 0 && rd_valid == 0 && rd_last == 0 && busy == 0, "reset_flags",
            {req_ready, rd_valid, rd_last, busy}, 0);
        chk(enet_rd_n && enet_wr_n && enet_cs_n && !enet_data_oe &&
            enet_data_o == 0 && !enet_cmd, "reset_bus",
            {enet_rd_n, enet_wr_n, enet_cs_n, enet_data_oe, enet_cmd, enet_data_o},
            {5'b11100, 16'h0000});
        @(posedge clk100); #1 rst = 1'b0;
        @(posedge clk100); @(negedge clk100);
        chk(req_ready == 1, "req_ready_after_reset", req_ready, 1);

        // 1: NSR register read
        do_req(8'h01, 12'd1, 16'h0040);
        wait_done();
        chk(appear_q.size() == 1 && appear_q[0] - acc == 11, "first_latency",
            appear_q.size() ? appear_q[0] - acc : -1, 11);
        chk(last_data == 16'h0040 && last_flag, "nsr_word", {last_flag, last_data}, 17'h10040);
        chk(wr_low == 2, "t1_wr_low", wr_low, 2);
        chk(rd_low == 4, "t1_rd_low", rd_low, 4);

        // 2: MRCMD burst, no backpressure
        do_req(8'hF2, 12'd4, 16'hA000);
        wait_done();
        chk(appear_q.size() == 4, "t2_words", appear_q.size(), 4);
        if (appear_q.size() == 4)
            for (int i = 1; i < 4; i++)
                chk(appear_q[i] - appear_q[i-1] == 8, "t2_spacing",
                    appear_q[i] - appear_q[i-1], 8);
        chk(last_data == 16'hA003 && last_flag, "t2_last_word", {last_flag, last_data}, 17'h1A003);
        chk(rd_low == 16 && wr_low == 2, "t2_strobes", {wr_low[15:0], rd_low[15:0]}, {16'd2, 16'd16});

        // 3: same burst with a 30-cycle stall after word 1
        do_req(8'hF2, 12'd4, 16'hB000);
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk100);
            if (n_consumed >= 1) begin ok = 1; break; end
        end
        chk(ok, "t3_word1", n_consumed, 1);
        @(posedge clk100); #1 rd_ready = 1'b0;
        strb = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk100);
            if (i >= 12 && !enet_rd_n) strb++;
        end
        chk(strb == 0, "t3_no_strobe_stalled", strb, 0);
        chk(rd_valid && rd_data == 16'hB001 && !rd_last, "t3_held_word",
            {rd_valid, rd_last, rd_data}, {2'b10, 16'hB001});
        @(posedge clk100); #1 rd_ready = 1'b1;
        wait_done();
        chk(n_consumed == 4 && last_data == 16'hB003 && last_flag, "t3_all_words",
            {n_consumed[14:0], last_flag, last_data}, {15'd4, 1'b1, 16'hB003});

        // 4: count 0 behaves as 1
        do_req(8'hFE, 12'd0, 16'hC0DE);
        wait_done();
        chk(rd_low == 4 && n_consumed == 1, "t4_single_read",
            {rd_low[15:0], n_consumed[15:0]}, {16'd4, 16'd1});
        chk(last_data == 16'hC0DE && last_flag, "t4_word", {last_flag, last_data}, 17'h1C0DE);

        // 5: reset in the middle of word 2's read strobe
        do_req(8'hF2, 12'd4, 16'hD000);
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk100);
            if (bus_k == 1 && !enet_rd_n) begin ok = 1; break; end
        end
        chk(ok, "t5_reach_word2", bus_k, 1);
        rst = 1'b1;
        @(posedge clk100); #1;
        chk(enet_rd_n && !enet_data_oe && !rd_valid && enet_cs_n && !busy, "t5_reset_state",
            {enet_rd_n, enet_data_oe, rd_valid, enet_cs_n, busy}, 5'b10010);
        exp_q.delete();
        rst = 1'b0;
        do_req(8'h01, 12'd1, 16'hE055);
        wait_done();
        chk(last_data == 16'hE055 && last_flag && n_consumed == 1, "t5_recovery",
            {n_consumed[14:0], last_flag, last_data}, {15'd1, 1'b1, 16'hE055});

        chk(exp_q.size() == 0, "no_lost_words", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
